framebuffer_writer: RTL and testbench



---
 rtl/framebuffer_pkg.sv | 25 ++
 rtl/fb_sync_fifo.sv | 58 +++++
 rtl/framebuffer_writer.sv | 216 +++++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_pkg.sv
// Shared types and constants for the SDRAM framebuffer write path.
package framebuffer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      NEXT  = 2'd2
   } fb_state_t;

   localparam int BURSTLENGTH_DEFAULT = 32;
   localparam int FRAME_WORDS_DEFAULT = 307200;

   localparam logic REG_BASE   = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_RESYNC    = 1;
   localparam int STAT_UNDERRUN  = 2;
   localparam int STAT_FRAME_LSB = 8;

   function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest word.
// Reset flushes pointers, occupancy and storage.
module fb_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   used,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (used == (AW+1)'(DEPTH));
   assign empty   = (used == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves used unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase
      end
   end

   // Word storage, written at the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel stream to SDRAM burst writer with frame sync and a two-register CSR.
// Optional build macro FRAMEBUFFER_WRITER_BYTESWAP_EN swaps the two bytes of
// each pixel on the way out; addressing and counting are unaffected.
module framebuffer_writer
   import framebuffer_pkg::*;
#(
   parameter int ADDR_W      = 26,
   parameter int DATA_W      = 16,
   parameter int BURSTLENGTH = BURSTLENGTH_DEFAULT,
   parameter int FIFO_DEPTH  = 64,
   parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_waitrequest,
   output logic [ADDR_W-1:0] m0_address,
   output logic              m0_write_n,
   output logic              m0_read_n,
   output logic [DATA_W-1:0] m0_writedata,
   output logic              m0_chipselect,
   output logic [1:0]        m0_byteenable_n,
   input  logic              s0_address,
   input  logic              s0_read,
   input  logic              s0_write,
   input  logic [31:0]       s0_writedata,
   output logic [31:0]       s0_readdata,
   output logic              snk_ready,
   input  logic              snk_valid,
   input  logic [DATA_W-1:0] snk_data,
   input  logic              snk_sof
);

   localparam int UW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] BL_U32 = 32'(BURSTLENGTH);
   localparam logic [31:0] FW_U32 = 32'(FRAME_WORDS);

   fb_state_t         state;
   fb_state_t         next_state;
   logic [DATA_W-1:0] fifo_head;
   logic [UW-1:0]     fifo_used;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [25:0]       shadow_base;
   logic [25:0]       active_base;
   logic              in_frame;
   logic              live;
   logic              resync_err;
   logic              underrun_wait;
   logic [7:0]        frame_count;
   logic [31:0]       word_count;
   logic [31:0]       pushed_count;
   logic [31:0]       burst_count;
   logic [31:0]       burst_len;
   logic [31:0]       remaining;
   logic [31:0]       used_w;
   logic [ADDR_W-1:0] offset;
   logic              sof_start;
   logic              latch_burst;
   logic              wr_base;
   logic              wr_status;
   logic              unused_wdata_bits;

   assign unused_wdata_bits = ^s0_writedata[31:26];

   assign used_w    = 32'(fifo_used);
   assign remaining = FW_U32 - word_count;
   assign wr_base   = s0_write && (s0_address == REG_BASE);
   assign wr_status = s0_write && (s0_address == REG_STATUS);

   // The enable tested at SOF is the freshly programmed shadow copy, so software
   // can arm the very next frame; the active copy only changes at that SOF.
   assign sof_start = live && !in_frame && snk_valid && snk_sof && shadow_base[0];

   assign snk_ready = live && (!in_frame || (!fifo_full && (pushed_count < FW_U32)));
   assign push      = snk_valid && snk_ready && (in_frame || sof_start);
   assign pop       = !m0_write_n && !m0_waitrequest;

   assign m0_read_n       = 1'b1;
   assign m0_chipselect   = !m0_write_n;
   assign m0_byteenable_n = 2'b00;
   assign m0_address      = ADDR_W'({active_base[25:1], 1'b0}) + offset
                            + ADDR_W'(burst_count << 1);

`ifdef FRAMEBUFFER_WRITER_BYTESWAP_EN
   assign m0_writedata = {fifo_head[7:0], fifo_head[15:8]};
`else
   assign m0_writedata = fifo_head;
`endif

   fb_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (snk_data),
      .dout  (fifo_head),
      .used  (fifo_used),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Holds snk_ready low until the first clock after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   // Burst state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Burst sequencing and the write strobe; the end-of-burst test uses the registered count.
   always_comb begin
      next_state  = state;
      latch_burst = 1'b0;
      m0_write_n  = 1'b1;
      case (state)
         IDLE: begin
            if ((used_w >= BL_U32) ||
                (in_frame && (remaining != 32'd0) && (remaining < BL_U32) && (used_w >= remaining))) begin
               next_state  = WRITE;
               latch_burst = 1'b1;
            end
         end
         WRITE: begin
            if ((burst_count < burst_len) && !fifo_empty) m0_write_n = 1'b0;
            if (burst_count == burst_len) next_state = NEXT;
         end
         NEXT: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Frame tracking, burst counters and SDRAM offset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_frame     <= 1'b0;
         active_base  <= '0;
         offset       <= '0;
         word_count   <= '0;
         pushed_count <= '0;
         burst_count  <= '0;
         burst_len    <= '0;
         frame_count  <= '0;
      end else begin
         if (latch_burst) burst_len <= min_u32(remaining, BL_U32);
         if (pop) begin
            burst_count <= burst_count + 32'd1;
            word_count  <= word_count + 32'd1;
         end
         if (state == NEXT) begin
            burst_count <= '0;
            if (word_count == FW_U32) begin
               in_frame    <= 1'b0;
               frame_count <= frame_count + 8'd1;
               offset      <= '0;
            end else begin
               offset <= offset + ADDR_W'(burst_len << 1);
            end
         end
         if (sof_start) begin
            in_frame     <= 1'b1;
            active_base  <= shadow_base;
            offset       <= '0;
            word_count   <= '0;
            pushed_count <= 32'd1;
         end else if (push) begin
            pushed_count <= pushed_count + 32'd1;
         end
      end
   end

   // Base register and sticky status flags; a new event wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_base   <= '0;
         resync_err    <= 1'b0;
         underrun_wait <= 1'b0;
      end else begin
         if (wr_base) shadow_base <= s0_writedata[25:0];
         if (wr_status) begin
            resync_err    <= 1'b0;
            underrun_wait <= 1'b0;
         end
         if (in_frame && push && snk_sof) resync_err <= 1'b1;
         if ((state == WRITE) && (burst_count < burst_len) && fifo_empty) underrun_wait <= 1'b1;
      end
   end

   // Register read mux.
   always_comb begin
      s0_readdata = '0;
      if (s0_read) begin
         if (s0_address == REG_BASE) begin
            s0_readdata[25:0] = active_base;
         end else begin
            s0_readdata[STAT_BUSY]            = (state != IDLE);
            s0_readdata[STAT_RESYNC]          = resync_err;
            s0_readdata[STAT_UNDERRUN]        = underrun_wait;
            s0_readdata[STAT_FRAME_LSB +: 8]  = frame_count;
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer built with a 72-word frame, so one
// frame exercises two full bursts followed by a short 8-word tail burst.
module tb_framebuffer_writer;
   import framebuffer_pkg::*;

   localparam int FW = 72;

   logic        clk;
   logic        rst;
   logic        m0_waitrequest;
   logic [25:0] m0_address;
   logic        m0_write_n;
   logic        m0_read_n;
   logic [15:0] m0_writedata;
   logic        m0_chipselect;
   logic [1:0]  m0_byteenable_n;
   logic        s0_address;
   logic        s0_read;
   logic        s0_write;
   logic [31:0] s0_writedata;
   logic [31:0] s0_readdata;
   logic        snk_ready;
   logic        snk_valid;
   logic [15:0] snk_data;
   logic        snk_sof;

   int checks   = 0;
   int failures = 0;
   int stall_mode = 0;
   int low_cycles = 0;
   logic [25:0] cap_addr[$];
   logic [15:0] cap_data[$];
   logic        prev_stall;
   logic [25:0] prev_addr;
   logic [15:0] prev_data;

   typedef struct {
      logic [31:0] base_reg;
      int          junk;
      int          stall;
      int          resync_at;
      int          dis_at;
      int          exp_words;
      logic [25:0] exp_addr0;
      logic [7:0]  exp_frames;
      logic        exp_resync;
      logic [31:0] exp_rd0;
   } frame_vec_t;

   frame_vec_t vecs[7];

   framebuffer_writer #(
      .ADDR_W      (26),
      .DATA_W      (16),
      .BURSTLENGTH (32),
      .FIFO_DEPTH  (64),
      .FRAME_WORDS (FW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .m0_waitrequest  (m0_waitrequest),
      .m0_address      (m0_address),
      .m0_write_n      (m0_write_n),
      .m0_read_n       (m0_read_n),
      .m0_writedata    (m0_writedata),
      .m0_chipselect   (m0_chipselect),
      .m0_byteenable_n (m0_byteenable_n),
      .s0_address      (s0_address),
      .s0_read         (s0_read),
      .s0_write        (s0_write),
      .s0_writedata    (s0_writedata),
      .s0_readdata     (s0_readdata),
      .snk_ready       (snk_ready),
      .snk_valid       (snk_valid),
      .snk_data        (snk_data),
      .snk_sof         (snk_sof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] expWord(input logic [15:0] px);
`ifdef FRAMEBUFFER_WRITER_BYTESWAP_EN
      return {px[7:0], px[15:8]};
`else
      return px;
`endif
   endfunction

   // Stall pattern on the SDRAM side, changed just after each rising edge.
   initial begin
      m0_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (stall_mode)
            1:       m0_waitrequest = ~m0_waitrequest;
            2:       m0_waitrequest = 1'b1;
            default: m0_waitrequest = 1'b0;
         endcase
      end
   end

   // Capture every accepted SDRAM write and confirm address/data hold across stalls.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("addr_hold_on_stall", 32'(m0_address), 32'(prev_addr));
            checkOutput("data_hold_on_stall", 32'(m0_writedata), 32'(prev_data));
         end
         if (!m0_write_n) low_cycles++;
         if (!m0_write_n && !m0_waitrequest) begin
            cap_addr.push_back(m0_address);
            cap_data.push_back(m0_writedata);
         end
         prev_stall = !m0_write_n && m0_waitrequest;
         prev_addr  = m0_address;
         prev_data  = m0_writedata;
      end
   end

   task automatic regWrite(input logic a, input logic [31:0] d);
      s0_write     = 1'b1;
      s0_address   = a;
      s0_writedata = d;
      @(posedge clk);
      #1;
      s0_write = 1'b0;
   endtask

   task automatic regRead(input logic a, output logic [31:0] d);
      s0_read    = 1'b1;
      s0_address = a;
      @(negedge clk);
      d = s0_readdata;
      @(posedge clk);
      #1;
      s0_read = 1'b0;
   endtask

   task automatic sendBeat(input logic [15:0] d, input logic sof, output logic ok);
      snk_valid = 1'b1;
      snk_data  = d;
      snk_sof   = sof;
      ok        = 1'b0;
      for (int c = 0; c < 500 && !ok; c++) begin
         @(negedge clk);
         if (snk_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      snk_valid = 1'b0;
      snk_sof   = 1'b0;
   endtask

   // Program the base, stream one frame and compare the resulting SDRAM traffic and CSRs.
   task automatic applyStimulus(input frame_vec_t v, input int k);
      logic        ok;
      int          lost;
      int          bad;
      logic [25:0] ea;
      logic [15:0] ed;
      logic [31:0] rd;
      lost = 0;
      bad  = 0;
      regWrite(REG_STATUS, 32'd0);
      regWrite(REG_BASE, v.base_reg);
      stall_mode = v.stall;
      cap_addr.delete();
      cap_data.delete();
      low_cycles = 0;
      for (int j = 0; j < v.junk; j++) begin
         sendBeat(16'hF000 + 16'(j), 1'b0, ok);
         if (!ok) lost++;
      end
      for (int i = 0; i < FW; i++) begin
         if (i == v.dis_at) begin
            s0_write     = 1'b1;
            s0_address   = REG_BASE;
            s0_writedata = v.base_reg & ~32'd1;
         end
         sendBeat(16'(k * 256 + i), (i == 0) || (i == v.resync_at), ok);
         s0_write = 1'b0;
         if (!ok) lost++;
      end
      for (int c = 0; c < 3000 && cap_addr.size() < v.exp_words; c++) @(negedge clk);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("beats_lost", 32'(lost), 32'd0);
      checkOutput("write_count", 32'(cap_addr.size()), 32'(v.exp_words));
      for (int i = 0; i < cap_addr.size() && i < v.exp_words; i++) begin
         ea = 26'(v.exp_addr0 + 26'(2 * i));
         ed = expWord(16'(k * 256 + i));
         if (cap_addr[i] !== ea || cap_data[i] !== ed) begin
            if (bad == 0)
               $display("[TB] vector %0d first bad beat %0d: addr %h want %h, data %h want %h",
                        k, i, cap_addr[i], ea, cap_data[i], ed);
            bad++;
         end
      end
      checkOutput("beat_addr_data", 32'(bad), 32'd0);
      if (v.stall == 0) checkOutput("write_n_low_cycles", 32'(low_cycles), 32'(v.exp_words));
      regRead(REG_STATUS, rd);
      checkOutput("frame_count", 32'(rd[15:8]), 32'(v.exp_frames));
      checkOutput("busy_after_frame", 32'(rd[STAT_BUSY]), 32'd0);
      checkOutput("resync_err", 32'(rd[STAT_RESYNC]), 32'(v.exp_resync));
      checkOutput("underrun_wait", 32'(rd[STAT_UNDERRUN]), 32'd0);
      regRead(REG_BASE, rd);
      checkOutput("active_base_readback", rd, v.exp_rd0);
      if (v.exp_resync) begin
         regWrite(REG_STATUS, 32'd0);
         regRead(REG_STATUS, rd);
         checkOutput("resync_err_cleared", 32'(rd[STAT_RESYNC]), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired before the test sequence ended");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      frame_vec_t  vr;
      logic        ok;
      logic [31:0] rd;

      //            base_reg      junk stall resync dis  words addr0        frames resync rd0
      vecs[0] = '{32'h0010_0001, 0,   0,    -1,    -1,  FW,   26'h010_0000, 8'd1,  1'b0, 32'h0010_0001};
      vecs[1] = '{32'h0010_0001, 0,   1,    -1,    -1,  FW,   26'h010_0000, 8'd2,  1'b0, 32'h0010_0001};
      vecs[2] = '{32'h0020_0001, 10,  0,    -1,    -1,  FW,   26'h020_0000, 8'd3,  1'b0, 32'h0020_0001};
      vecs[3] = '{32'h0030_0001, 0,   1,    20,    -1,  FW,   26'h030_0000, 8'd4,  1'b1, 32'h0030_0001};
      vecs[4] = '{32'h03FF_FFC1, 0,   0,    -1,    -1,  FW,   26'h3FF_FFC0, 8'd5,  1'b0, 32'h03FF_FFC1};
      vecs[5] = '{32'h0050_0001, 3,   0,    -1,    30,  FW,   26'h050_0000, 8'd6,  1'b0, 32'h0050_0001};
      vecs[6] = '{32'h0040_0000, 0,   0,    -1,    -1,  0,    26'h000_0000, 8'd6,  1'b0, 32'h0050_0001};

      rst          = 1'b1;
      snk_valid    = 1'b0;
      snk_data     = '0;
      snk_sof      = 1'b0;
      s0_address   = 1'b0;
      s0_read      = 1'b0;
      s0_write     = 1'b0;
      s0_writedata = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_write_n", 32'(m0_write_n), 32'd1);
      checkOutput("reset_snk_ready", 32'(snk_ready), 32'd0);
      checkOutput("reset_address", 32'(m0_address), 32'd0);
      checkOutput("read_n_tied", 32'(m0_read_n), 32'd1);
      checkOutput("chipselect_idle", 32'(m0_chipselect), 32'd0);
      checkOutput("byteenable_tied", 32'(m0_byteenable_n), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      regRead(REG_STATUS, rd);
      checkOutput("reset_status", rd, 32'd0);
      regRead(REG_BASE, rd);
      checkOutput("reset_active_base", rd, 32'd0);

      for (int k = 0; k < 7; k++) begin
         $display("[TB] frame vector %0d", k);
         applyStimulus(vecs[k], k);
      end

      // Reset while a burst is stalled in WRITE with 40 words queued.
      $display("[TB] reset during burst");
      stall_mode = 2;
      regWrite(REG_BASE, 32'h0010_0001);
      for (int i = 0; i < 40; i++) begin
         sendBeat(16'h0A00 + 16'(i), i == 0, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("[TB] FAIL pre_reset_beat actual=0 required=1 (beat %0d)", i);
         end
      end
      repeat (3) @(negedge clk);
      checkOutput("write_active_pre_reset", 32'(m0_write_n), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("reset_async_write_n", 32'(m0_write_n), 32'd1);
      checkOutput("reset_async_snk_ready", 32'(snk_ready), 32'd0);
      checkOutput("reset_async_address", 32'(m0_address), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stall_mode = 0;
      regRead(REG_STATUS, rd);
      checkOutput("status_after_reset", rd, 32'd0);
      vr            = vecs[0];
      vr.exp_frames = 8'd1;
      applyStimulus(vr, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
